// File: rtl/ds_inst_queue_pkg.sv
// Shared widths and state-update kinds for the fetch-to-decode instruction queue.
// Widths mirror FS_TO_DS_BUS_WD / FS_EX_BUS_WD from mycpu.h.
package ds_inst_queue_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int FS_EX_BUS_WD    = 8;

  typedef enum logic [2:0] {
    UPD_NORMAL,
    UPD_CLEAR,
    UPD_SQ_POP,
    UPD_SQ_KEEP,
    UPD_SQ_FILL,
    UPD_SQ_PEND
  } dq_upd_e;

endpackage

// File: rtl/ds_inst_queue.sv
// DEPTH-entry queue between fetch and decode with flush and delay-slot-preserving squash.
// Defining DQ_BYPASS_EN adds a combinational fetch-to-decode path when the queue is empty.
module ds_inst_queue
  import ds_inst_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_WD = FS_TO_DS_BUS_WD,
  parameter int EX_WD   = FS_EX_BUS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [DATA_WD-1:0]         fs_to_ds_bus,
  input  logic [EX_WD-1:0]           fs_ex_bus,
  output logic                       dq_allowin,
  output logic                       dq_to_ds_valid,
  output logic [DATA_WD-1:0]         dq_to_ds_bus,
  output logic [EX_WD-1:0]           dq_ex_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  input  logic                       br_squash,
  output logic [$clog2(DEPTH):0]     dq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = EX_WD + DATA_WD;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_ds_q, pend_ds_d;
  logic          q_nonempty, bypass, push, pop, pop_mem, wr_en;
  dq_upd_e       upd;

  assign q_nonempty = (count_q != '0);
  assign dq_allowin = (count_q < CW'(DEPTH));
  assign dq_count   = count_q;

`ifdef DQ_BYPASS_EN
  assign bypass = ~q_nonempty & fs_to_ds_valid & ~flush;
  assign {dq_ex_bus, dq_to_ds_bus} = bypass ? {fs_ex_bus, fs_to_ds_bus} : mem_q[rd_ptr_q];
`else
  assign bypass = 1'b0;
  assign {dq_ex_bus, dq_to_ds_bus} = mem_q[rd_ptr_q];
`endif

  assign dq_to_ds_valid = q_nonempty | bypass;
  assign push    = fs_to_ds_valid & dq_allowin;
  assign pop     = dq_to_ds_valid & ds_allowin;
  assign pop_mem = pop & q_nonempty;

  // On squash the entry right behind the branch is the delay slot; it must survive.
  always_comb begin
    upd = UPD_NORMAL;
    if (reset || flush) begin
      upd = UPD_CLEAR;
    end else if (br_squash) begin
      if (pop)             upd = UPD_SQ_POP;
      else if (q_nonempty) upd = UPD_SQ_KEEP;
      else if (push)       upd = UPD_SQ_FILL;
      else                 upd = UPD_SQ_PEND;
    end
  end

  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pend_ds_d = pend_ds_q;
    wr_en     = 1'b0;
    case (upd)
      UPD_CLEAR: begin
        count_d   = '0;
        rd_ptr_d  = '0;
        wr_ptr_d  = '0;
        pend_ds_d = 1'b0;
      end
      UPD_SQ_POP: begin
        rd_ptr_d  = pop_mem ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d  = rd_ptr_d;
        count_d   = '0;
        pend_ds_d = 1'b0;
      end
      UPD_SQ_KEEP: begin
        wr_ptr_d = rd_ptr_q + PW'(1);
        count_d  = CW'(1);
      end
      UPD_SQ_FILL: begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + PW'(1);
        count_d   = CW'(1);
        pend_ds_d = 1'b0;
      end
      UPD_SQ_PEND: begin
        pend_ds_d = 1'b1;
      end
      default: begin
        // A bypassed entry that decode takes immediately never touches storage.
        wr_en    = push & ~(bypass & pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_mem ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop_mem);
        if (push) pend_ds_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      pend_ds_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      pend_ds_q <= pend_ds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {fs_ex_bus, fs_to_ds_bus};
  end

endmodule

// File: tb/tb_ds_inst_queue.sv
// Directed bench for ds_inst_queue (default build, DEPTH=4, 64-bit payload, 8-bit ex bus).
module tb_ds_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [7:0]  fs_ex_bus;
  logic        dq_allowin;
  logic        dq_to_ds_valid;
  logic [63:0] dq_to_ds_bus;
  logic [7:0]  dq_ex_bus;
  logic        ds_allowin;
  logic        flush;
  logic        br_squash;
  logic [2:0]  dq_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ds_inst_queue #(.DEPTH(4), .DATA_WD(64), .EX_WD(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .fs_ex_bus      (fs_ex_bus),
    .dq_allowin     (dq_allowin),
    .dq_to_ds_valid (dq_to_ds_valid),
    .dq_to_ds_bus   (dq_to_ds_bus),
    .dq_ex_bus      (dq_ex_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .br_squash      (br_squash),
    .dq_count       (dq_count)
  );

  function automatic logic [63:0] mk_bus(input logic [31:0] pc);
    return {pc + 32'h0C00_0000, pc};
  endfunction

  function automatic logic [7:0] mk_ex(input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
    return p[9:2] ^ 8'h5A;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    fs_to_ds_valid = v;
    fs_to_ds_bus   = mk_bus(pc);
    fs_ex_bus      = mk_ex(pc);
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; br_squash = 1'b0; ds_allowin = 1'b0;
    drive(1'b0, 32'h0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (dq_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", dq_to_ds_valid); end
    n_vec++;
    if (dq_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", dq_allowin); end
    n_vec++;
    if (dq_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", dq_count); end
    reset = 1'b0;
  endtask

  task automatic test_fill;
    ds_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i));
      @(negedge clk);
      n_vec++;
      if (dq_count !== 3'((i < 4) ? i + 1 : 4)) begin
        n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, dq_count, (i < 4) ? i + 1 : 4);
      end
      if (i == 3) begin
        n_vec++;
        if (dq_allowin !== 1'b0) begin n_err++; $display("FAIL full_allowin got %b want 0", dq_allowin); end
      end
    end
    drive(1'b0, 32'h0);
    ds_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (dq_to_ds_valid !== 1'b1 || dq_to_ds_bus !== mk_bus(32'h1000 + 32'(4 * i))) begin
        n_err++; $display("FAIL drain_head[%0d] got v=%b %h want v=1 %h", i, dq_to_ds_valid, dq_to_ds_bus, mk_bus(32'h1000 + 32'(4 * i)));
      end
      @(negedge clk);
    end
    n_vec++;
    if (dq_count !== 3'd0 || dq_to_ds_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_empty got count=%0d v=%b want 0 0", dq_count, dq_to_ds_valid);
    end
    ds_allowin = 1'b0;
  endtask

  task automatic test_back_to_back;
    ds_allowin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i));
      @(negedge clk);
      n_vec++;
      if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h2000 + 32'(4 * i)) || dq_ex_bus !== mk_ex(32'h2000 + 32'(4 * i))) begin
        n_err++; $display("FAIL stream[%0d] got count=%0d bus=%h ex=%h want 1 %h %h", i, dq_count, dq_to_ds_bus, dq_ex_bus, mk_bus(32'h2000 + 32'(4 * i)), mk_ex(32'h2000 + 32'(4 * i)));
      end
    end
    drive(1'b0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (dq_count !== 3'd0) begin n_err++; $display("FAIL stream_end_count got %0d want 0", dq_count); end
    ds_allowin = 1'b0;
  endtask

  task automatic test_squash_keep;
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i));
      @(negedge clk);
    end
    n_vec++;
    if (dq_count !== 3'd3) begin n_err++; $display("FAIL sqk_pre_count got %0d want 3", dq_count); end
    drive(1'b1, 32'h300C);
    br_squash = 1'b1;
    @(negedge clk);
    br_squash = 1'b0;
    n_vec++;
    if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h3000)) begin
      n_err++; $display("FAIL sqk_keep got count=%0d bus=%h want 1 %h", dq_count, dq_to_ds_bus, mk_bus(32'h3000));
    end
    drive(1'b1, 32'h3010);
    @(negedge clk);
    n_vec++;
    if (dq_count !== 3'd2) begin n_err++; $display("FAIL sqk_refill_count got %0d want 2", dq_count); end
    drive(1'b0, 32'h0);
    ds_allowin = 1'b1;
    n_vec++;
    if (dq_to_ds_bus !== mk_bus(32'h3000)) begin n_err++; $display("FAIL sqk_pop0 got %h want %h", dq_to_ds_bus, mk_bus(32'h3000)); end
    @(negedge clk);
    n_vec++;
    if (dq_to_ds_valid !== 1'b1 || dq_to_ds_bus !== mk_bus(32'h3010)) begin
      n_err++; $display("FAIL sqk_pop1 got v=%b %h want v=1 %h", dq_to_ds_valid, dq_to_ds_bus, mk_bus(32'h3010));
    end
    @(negedge clk);
    n_vec++;
    if (dq_count !== 3'd0) begin n_err++; $display("FAIL sqk_end_count got %0d want 0", dq_count); end
    ds_allowin = 1'b0;
  endtask

  task automatic test_pop_squash;
    ds_allowin = 1'b0;
    drive(1'b1, 32'h4000); @(negedge clk);
    drive(1'b1, 32'h4004); @(negedge clk);
    n_vec++;
    if (dq_count !== 3'd2) begin n_err++; $display("FAIL psq_pre_count got %0d want 2", dq_count); end
    drive(1'b1, 32'h4008);
    ds_allowin = 1'b1;
    br_squash  = 1'b1;
    n_vec++;
    if (dq_to_ds_valid !== 1'b1 || dq_to_ds_bus !== mk_bus(32'h4000)) begin
      n_err++; $display("FAIL psq_popped got v=%b %h want v=1 %h", dq_to_ds_valid, dq_to_ds_bus, mk_bus(32'h4000));
    end
    @(negedge clk);
    br_squash = 1'b0; ds_allowin = 1'b0;
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd0 || dq_to_ds_valid !== 1'b0) begin
      n_err++; $display("FAIL psq_empty got count=%0d v=%b want 0 0", dq_count, dq_to_ds_valid);
    end
    drive(1'b1, 32'h4010); @(negedge clk);
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h4010)) begin
      n_err++; $display("FAIL psq_next got count=%0d bus=%h want 1 %h", dq_count, dq_to_ds_bus, mk_bus(32'h4010));
    end
    ds_allowin = 1'b1; @(negedge clk); ds_allowin = 1'b0;
  endtask

  task automatic test_pend_ds;
    drive(1'b0, 32'h0);
    br_squash = 1'b1;
    @(negedge clk);
    br_squash = 1'b0;
    n_vec++;
    if (dq_count !== 3'd0 || dq_to_ds_valid !== 1'b0) begin
      n_err++; $display("FAIL pend_empty got count=%0d v=%b want 0 0", dq_count, dq_to_ds_valid);
    end
    @(negedge clk);
    drive(1'b1, 32'h5000); @(negedge clk);
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h5000)) begin
      n_err++; $display("FAIL pend_accept got count=%0d bus=%h want 1 %h", dq_count, dq_to_ds_bus, mk_bus(32'h5000));
    end
    ds_allowin = 1'b1; @(negedge clk); ds_allowin = 1'b0;
    drive(1'b1, 32'h5100);
    br_squash = 1'b1;
    @(negedge clk);
    br_squash = 1'b0;
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h5100)) begin
      n_err++; $display("FAIL sq_fill got count=%0d bus=%h want 1 %h", dq_count, dq_to_ds_bus, mk_bus(32'h5100));
    end
    ds_allowin = 1'b1; @(negedge clk); ds_allowin = 1'b0;
  endtask

  task automatic test_flush;
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * i)); @(negedge clk);
    end
    flush = 1'b1;
    drive(1'b1, 32'h600C);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd0 || dq_to_ds_valid !== 1'b0 || dq_allowin !== 1'b1) begin
      n_err++; $display("FAIL flush got count=%0d v=%b allowin=%b want 0 0 1", dq_count, dq_to_ds_valid, dq_allowin);
    end
    drive(1'b1, 32'h6010); @(negedge clk);
    drive(1'b1, 32'h6014); @(negedge clk);
    drive(1'b1, 32'h6018); @(negedge clk);
    n_vec++;
    if (dq_count !== 3'd3 || dq_to_ds_bus !== mk_bus(32'h6010)) begin
      n_err++; $display("FAIL post_flush got count=%0d bus=%h want 3 %h", dq_count, dq_to_ds_bus, mk_bus(32'h6010));
    end
    reset = 1'b1;
    drive(1'b1, 32'h601C);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd0 || dq_to_ds_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset got count=%0d v=%b want 0 0", dq_count, dq_to_ds_valid);
    end
    drive(1'b1, 32'h6020); @(negedge clk);
    drive(1'b0, 32'h0);
    n_vec++;
    if (dq_count !== 3'd1 || dq_to_ds_bus !== mk_bus(32'h6020)) begin
      n_err++; $display("FAIL post_reset got count=%0d bus=%h want 1 %h", dq_count, dq_to_ds_bus, mk_bus(32'h6020));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_squash_keep();
    test_pop_squash();
    test_pend_ds();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
